// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
//   arb_state_t : issue-slot FSM state
//   arb_owner_t : requester that owns the outstanding read
//   MEM_BE_ALL  : full-word byte enable used for fetches and loads
//   LAT_W       : width of the read-latency counter (RD_LAT up to 4)
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  localparam logic [3:0] MEM_BE_ALL = 4'b1111;

  localparam int unsigned LAT_W = 3;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arb.sv
// Shares one single-port RAM between instruction fetch (IF) and load/store (LS).
// Arbitrates the issue slot (LS wins ties), sequences fixed-latency reads,
// routes read data back to the owner, and stalls ctrl while LS is waiting.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                IF fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata     IF grant pulse, read-data pulse and data
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata   LS request and payload, held until ls_gnt
//   ls_gnt/ls_rvalid/ls_rdata     LS grant pulse, load-data pulse and data
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata   RAM command (driven in the issue cycle)
//   mem_rdata                     RAM read data, valid RD_LAT cycles after issue
//   stall                         LS pending and not granted, or LS load outstanding
//
// Build option: define MEM_ARB_STARVE_GUARD_EN to hand the slot to a waiting IF
// after STARVE_MAX consecutive LS grants; otherwise LS priority is strict.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic rd_done;
  logic slot_open;
  logic ls_issue;
  logic if_issue;
  logic starve_block;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned ST_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  logic [ST_W-1:0] starve_q, starve_d;

  // IF takes the slot once LS has won STARVE_MAX times in a row while IF waited
  assign starve_block = if_req && (starve_q >= ST_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_issue) begin
      starve_d = '0;
    end else if (ls_issue) begin
      starve_d = starve_q + ST_W'(1);
    end
  end
`else
  assign starve_block = 1'b0;

  logic unused_starve_max;
  assign unused_starve_max = ^32'(STARVE_MAX);
`endif

  // State, owner, latency counter and held data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IF;
      lat_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q   <= starve_d;
`endif
    end
  end

  // Next-state: slot arbitration and read sequencing
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;

    // The data-return cycle doubles as the next issue slot
    rd_done   = (state_q == ARB_RD_WAIT) && (lat_q == LAT_W'(RD_LAT));
    slot_open = (state_q == ARB_IDLE) || rd_done;
    ls_issue  = slot_open && ls_req && !starve_block;
    if_issue  = slot_open && if_req && !ls_issue;

    if (rd_done) begin
      state_d = ARB_IDLE;
      if (owner_q == OWN_LS) begin
        ls_rdata_d = mem_rdata;
      end else begin
        if_rdata_d = mem_rdata;
      end
    end else if (state_q == ARB_RD_WAIT) begin
      lat_d = lat_q + LAT_W'(1);
    end

    if (ls_issue) begin
      addr_d  = ls_addr;
      wdata_d = ls_wdata;
      // Stores finish at grant; only loads open a read window
      if (!ls_we) begin
        state_d = ARB_RD_WAIT;
        owner_d = OWN_LS;
        lat_d   = LAT_W'(1);
      end
    end else if (if_issue) begin
      addr_d  = if_addr;
      state_d = ARB_RD_WAIT;
      owner_d = OWN_IF;
      lat_d   = LAT_W'(1);
    end
  end

  // Output routing; everything is forced quiet while rst is low
  always_comb begin
    if_gnt    = rst && if_issue;
    ls_gnt    = rst && ls_issue;
    if_rvalid = rst && rd_done && (owner_q == OWN_IF);
    ls_rvalid = rst && rd_done && (owner_q == OWN_LS);

    mem_en    = if_gnt || ls_gnt;
    mem_we    = ls_gnt && ls_we;
    mem_be    = '0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (ls_gnt) begin
      mem_be    = ls_we ? ls_be : MEM_BE_ALL;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_be    = MEM_BE_ALL;
      mem_addr  = if_addr;
    end

    if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    ls_rdata = ls_rvalid ? mem_rdata : ls_rdata_q;

    stall = rst && ((ls_req && !ls_issue) ||
                    ((owner_q == OWN_LS) && (state_q == ARB_RD_WAIT) && !rd_done));
  end

endmodule : mem_port_arb

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: two instances (RD_LAT = 1 and 3), each with its own
// random requesters and a transaction-level model (pending read + due cycle).
// Honours MEM_ARB_STARVE_GUARD_EN the same way the design does.
module tb_mem_port_arb;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int          N_CYC      = 2500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    logic              rst, if_req, if_gnt, if_rvalid;
    logic              ls_req, ls_we, ls_gnt, ls_rvalid;
    logic              mem_en, mem_we, stall;
    logic [3:0]        ls_be, mem_be;
    logic [ADDR_W-1:0] if_addr, ls_addr, mem_addr;
    logic [DATA_W-1:0] if_rdata, ls_wdata, ls_rdata, mem_wdata, mem_rdata;

    mem_port_arb #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RD_LAT    (LAT),
      .STARVE_MAX(STARVE_MAX)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .ls_req   (ls_req),
      .ls_we    (ls_we),
      .ls_be    (ls_be),
      .ls_addr  (ls_addr),
      .ls_wdata (ls_wdata),
      .ls_gnt   (ls_gnt),
      .ls_rvalid(ls_rvalid),
      .ls_rdata (ls_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_be   (mem_be),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .stall    (stall)
    );

    initial begin : stim
      bit                pend_v, pend_ls, due_now, open, blk;
      bit                prev_if_gnt, prev_ls_gnt, prev_ld_gnt;
      int                pend_due, rst_cnt, n_rst;
      int unsigned       p_if, p_ls, starve;
      logic [ADDR_W-1:0] pc, last_addr, e_addr;
      logic [DATA_W-1:0] last_wdata, if_hold, ls_hold, e_wdata, e_if_rdata, e_ls_rdata;
      logic              e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_we, e_stall;
      logic [3:0]        e_be;
      string             pfx;

      pfx = $sformatf("L%0d", LAT);
      pend_v = 0; pend_ls = 0; pend_due = 0; starve = 0;
      prev_if_gnt = 0; prev_ls_gnt = 0; prev_ld_gnt = 0;
      rst_cnt = 3; n_rst = 0; pc = '0;
      last_addr = '0; last_wdata = '0; if_hold = '0; ls_hold = '0;
      rst = 1'b0; if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
      mem_rdata = '0;
      @(posedge clk); #1;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
        // Reset pulses, mostly landing while a load is in flight
        if (rst_cnt == 0 && prev_ld_gnt && n_rst < 6 && $urandom_range(0, 2) == 0) begin
          rst_cnt = 2;
          n_rst++;
        end
        rst = (rst_cnt == 0);
        if (rst_cnt > 0) rst_cnt--;

        // Phases: fetch-only start, mixed traffic, saturation, LS-heavy
        if (cyc < 12)        begin p_if = 100; p_ls = 0;   end
        else if (cyc < 900)  begin p_if = 50;  p_ls = 50;  end
        else if (cyc < 1500) begin p_if = 100; p_ls = 100; end
        else                 begin p_if = 30;  p_ls = 80;  end

        if (prev_if_gnt) pc = pc + 32'd4;
        if (!if_req || prev_if_gnt) begin
          if (cyc >= 12 && $urandom_range(0, 15) == 0) pc = $urandom & 32'hFFFF_FFFC;
          if_req  = ($urandom_range(0, 99) < p_if);
          if_addr = pc;
        end else if ($urandom_range(0, 31) == 0) begin
          if_req = 1'b0;
        end

        if (!ls_req || prev_ls_gnt) begin
          ls_req   = ($urandom_range(0, 99) < p_ls);
          ls_we    = ($urandom_range(0, 2) == 0);
          ls_be    = 4'($urandom);
          ls_addr  = $urandom & 32'hFFFF_FFFC;
          ls_wdata = $urandom;
        end else if ($urandom_range(0, 31) == 0) begin
          ls_req = 1'b0;
        end

        mem_rdata = $urandom;

        @(negedge clk);

        if (!rst) begin
          pend_v = 0; starve = 0;
          last_addr = '0; last_wdata = '0; if_hold = '0; ls_hold = '0;
        end
        due_now = pend_v && (pend_due == cyc);
        open    = rst && (!pend_v || due_now);
        blk     = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        blk     = if_req && (starve >= STARVE_MAX);
`endif
        e_ls_gnt   = open && ls_req && !blk;
        e_if_gnt   = open && if_req && !e_ls_gnt;
        e_ls_rv    = rst && due_now && pend_ls;
        e_if_rv    = rst && due_now && !pend_ls;
        e_we       = e_ls_gnt && ls_we;
        e_be       = e_ls_gnt ? (ls_we ? ls_be : 4'hF) : (e_if_gnt ? 4'hF : 4'h0);
        e_addr     = e_ls_gnt ? ls_addr : (e_if_gnt ? if_addr : last_addr);
        e_wdata    = e_ls_gnt ? ls_wdata : last_wdata;
        e_if_rdata = e_if_rv ? mem_rdata : if_hold;
        e_ls_rdata = e_ls_rv ? mem_rdata : ls_hold;
        e_stall    = rst && ((ls_req && !e_ls_gnt) || (pend_v && pend_ls && !due_now));

        check({pfx, "/if_gnt"},    32'(if_gnt),    32'(e_if_gnt));
        check({pfx, "/ls_gnt"},    32'(ls_gnt),    32'(e_ls_gnt));
        check({pfx, "/if_rvalid"}, 32'(if_rvalid), 32'(e_if_rv));
        check({pfx, "/ls_rvalid"}, 32'(ls_rvalid), 32'(e_ls_rv));
        check({pfx, "/mem_en"},    32'(mem_en),    32'(e_if_gnt || e_ls_gnt));
        check({pfx, "/mem_we"},    32'(mem_we),    32'(e_we));
        check({pfx, "/mem_be"},    32'(mem_be),    32'(e_be));
        check({pfx, "/mem_addr"},  mem_addr,       e_addr);
        check({pfx, "/mem_wdata"}, mem_wdata,      e_wdata);
        check({pfx, "/if_rdata"},  if_rdata,       e_if_rdata);
        check({pfx, "/ls_rdata"},  ls_rdata,       e_ls_rdata);
        check({pfx, "/stall"},     32'(stall),     32'(e_stall));

        last_addr  = e_addr;
        last_wdata = e_wdata;
        if_hold    = e_if_rdata;
        ls_hold    = e_ls_rdata;
        if (e_if_gnt || (e_ls_gnt && !ls_we)) begin
          pend_v   = 1;
          pend_ls  = e_ls_gnt;
          pend_due = cyc + int'(LAT);
        end else if (due_now) begin
          pend_v = 0;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (!if_req || e_if_gnt) starve = 0;
        else if (e_ls_gnt)       starve++;
`endif
        prev_if_gnt = e_if_gnt;
        prev_ls_gnt = e_ls_gnt;
        prev_ld_gnt = e_ls_gnt && !ls_we;

        @(posedge clk); #1;
      end
      n_done++;
    end
  end

  initial begin : finish_ctl
    for (int i = 0; i < N_CYC + 50; i++) begin
      if (n_done == 2) break;
      @(posedge clk);
    end
    check("instances_done", 32'(n_done), 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mem_port_arb
